// File: rtl/ov7670_pkg.sv
// Shared constants for the OV7670 configuration path: table markers, sequencer states,
// camera register addresses and the default power-up table.
package ov7670_pkg;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

    localparam int unsigned TableDepth = 256;
    localparam int unsigned TableBits  = TableDepth * 16;

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StFetch      = 4'd1,
        StDecode     = 4'd2,
        StIssue      = 4'd3,
        StWaitAccept = 4'd4,
        StWaitDone   = 4'd5,
        StGap        = 4'd6,
        StDelay      = 4'd7,
        StDone       = 4'd8
    } seq_state_e;

    localparam logic [7:0] REG_CLKRC  = 8'h11;
    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_COM3   = 8'h0C;
    localparam logic [7:0] REG_COM10  = 8'h15;
    localparam logic [7:0] REG_TSLB   = 8'h3A;
    localparam logic [7:0] REG_COM13  = 8'h3D;
    localparam logic [7:0] REG_COM14  = 8'h3E;
    localparam logic [7:0] REG_COM15  = 8'h40;
    localparam logic [7:0] REG_RGB444 = 8'h8C;

    // Soft reset, settle delay, then RGB565 at VGA resolution; unused slots read as end marker.
    function automatic logic [TableBits-1:0] default_table();
        logic [15:0]          e [12];
        logic [TableBits-1:0] t;
        e = '{
            {REG_COM7,   8'h80},
            ENTRY_DELAY,
            {REG_COM7,   8'h04},
            {REG_CLKRC,  8'h01},
            {REG_COM3,   8'h00},
            {REG_COM14,  8'h00},
            {REG_COM15,  8'hD0},
            {REG_RGB444, 8'h00},
            {REG_TSLB,   8'h04},
            {REG_COM13,  8'hC0},
            {REG_COM10,  8'h00},
            ENTRY_END
        };
        t = {TableDepth{ENTRY_END}};
        for (int i = 0; i < 12; i++) begin
            t[12'(i * 16) +: 16] = e[i];
        end
        return t;
    endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// Register/value table with a one-cycle registered read. Swap the Table parameter to change
// the camera setup without touching the sequencer.
module ov7670_config_rom
    import ov7670_pkg::*;
#(
    parameter logic [TableBits-1:0] Table = default_table()
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  i_addr,
    output logic [15:0] o_data
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            o_data <= 16'h0000;
        end else begin
            o_data <= Table[{i_addr, 4'h0} +: 16];
        end
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// OV7670 power-up sequencer: walks the config ROM, issues one SCCB write per entry through the
// writer's ready/busy handshake, honours delay markers and reports done or error.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int unsigned          ClockFrequency = 50_000_000,
    parameter int unsigned          DelayMs        = 10,
    parameter int unsigned          GapCycles      = 64,
    parameter int unsigned          AcceptTimeout  = 16,
    parameter logic [TableBits-1:0] Table          = default_table()
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_start,
    output logic [7:0] o_sccb_addr,
    output logic [7:0] o_sccb_data,
    output logic       o_sccb_ready,
    input  logic       i_sccb_busy,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [7:0] o_index
);

    localparam int unsigned DelayCycles = DelayMs * (ClockFrequency / 1000);
    localparam int unsigned DlyW        = $clog2(DelayCycles + 1);
    localparam int unsigned GapW        = $clog2(GapCycles + 1);
    localparam int unsigned AccW        = $clog2(AcceptTimeout + 1);

    localparam logic [DlyW-1:0] DlyLast = DlyW'(DelayCycles - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
    localparam logic [AccW-1:0] AccLast = AccW'(AcceptTimeout - 1);

    seq_state_e      state_q;
    logic [7:0]      index_q;
    logic [7:0]      addr_q;
    logic [7:0]      data_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [DlyW-1:0] dly_cnt_q;
    logic [GapW-1:0] gap_cnt_q;
    logic [AccW-1:0] acc_cnt_q;
    logic [15:0]     rom_data;
    logic            last_entry;

    ov7670_config_rom #(
        .Table (Table)
    ) u_rom (
        .CLK    (CLK),
        .RST    (RST),
        .i_addr (index_q),
        .o_data (rom_data)
    );

    // Index 255 is the final slot; advancing past it ends the table, never wraps.
    assign last_entry = (index_q == 8'hFF);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            index_q   <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            dly_cnt_q <= '0;
            gap_cnt_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        index_q <= 8'h00;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StDecode;
                end
                StDecode: begin
                    if (rom_data == ENTRY_END) begin
                        state_q <= StDone;
                    end else if (rom_data == ENTRY_DELAY) begin
                        dly_cnt_q <= '0;
                        state_q   <= StDelay;
                    end else begin
                        addr_q  <= rom_data[15:8];
                        data_q  <= rom_data[7:0];
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!i_sccb_busy) begin
                        ready_q   <= 1'b1;
                        acc_cnt_q <= '0;
                        state_q   <= StWaitAccept;
                    end
                end
                StWaitAccept: begin
                    if (i_sccb_busy) begin
                        state_q <= StWaitDone;
                    end else if (acc_cnt_q == AccLast) begin
                        error_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        acc_cnt_q <= acc_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!i_sccb_busy) begin
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        if (last_entry) begin
                            state_q <= StDone;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= StFetch;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StDelay: begin
                    if (dly_cnt_q == DlyLast) begin
                        if (last_entry) begin
                            state_q <= StDone;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= StFetch;
                        end
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_sccb_addr  = addr_q;
    assign o_sccb_data  = data_q;
    assign o_sccb_ready = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_index      = index_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: two instances (short table with a delay, full 256-write
// table) driven by a bus-functional SCCB writer; writes are checked against a scoreboard queue.
module tb_ov7670_config_sequencer;

    localparam int unsigned FreqHz    = 1_000_000;
    localparam int unsigned DlyMs     = 1;
    localparam int unsigned DlyCycles = DlyMs * (FreqHz / 1000);
    localparam int unsigned GapA      = 4;
    localparam int unsigned GapB      = 2;
    localparam int unsigned AccA      = 16;
    localparam int unsigned AccB      = 8;
    localparam int          HoldA     = 100;
    localparam int          HoldB     = 3;

    localparam int CDone   = 0;
    localparam int CRdy    = 1;
    localparam int CErr    = 2;
    localparam int CBusyHi = 3;
    localparam int CBusyLo = 4;

    function automatic logic [4095:0] table_a();
        logic [4095:0] t;
        t = {256{16'hFFFF}};
        t[15:0]  = 16'h1280;
        t[31:16] = 16'hFFF0;
        return t;
    endfunction

    function automatic logic [4095:0] table_b();
        logic [4095:0] t;
        for (int i = 0; i < 256; i++) begin
            t[12'(i * 16) +: 16] = {8'(i), ~8'(i)};
        end
        return t;
    endfunction

    localparam logic [4095:0] TableA = table_a();
    localparam logic [4095:0] TableB = table_b();

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = 2'b00;
    logic [1:0] force_busy = 2'b00;
    logic [1:0] never = 2'b00;
    logic [1:0] rdy, dbusy, done, err;
    logic [1:0] wbusy, rdy_d, rdy_prev = 2'b00;
    logic [1:0] sccb_busy;
    logic [7:0] addr [2];
    logic [7:0] data [2];
    logic [7:0] index [2];
    int         hold_cnt [2];
    int         rdy_cnt [2];
    int         total = 0;
    int         bad = 0;
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    assign sccb_busy = wbusy | force_busy;

    always #5 clk = ~clk;

    ov7670_config_sequencer #(
        .ClockFrequency (FreqHz),
        .DelayMs        (DlyMs),
        .GapCycles      (GapA),
        .AcceptTimeout  (AccA),
        .Table          (TableA)
    ) dut_a (
        .CLK          (clk),
        .RST          (rst_n),
        .i_start      (start[0]),
        .o_sccb_addr  (addr[0]),
        .o_sccb_data  (data[0]),
        .o_sccb_ready (rdy[0]),
        .i_sccb_busy  (sccb_busy[0]),
        .o_busy       (dbusy[0]),
        .o_done       (done[0]),
        .o_error      (err[0]),
        .o_index      (index[0])
    );

    ov7670_config_sequencer #(
        .ClockFrequency (FreqHz),
        .DelayMs        (DlyMs),
        .GapCycles      (GapB),
        .AcceptTimeout  (AccB),
        .Table          (TableB)
    ) dut_b (
        .CLK          (clk),
        .RST          (rst_n),
        .i_start      (start[1]),
        .o_sccb_addr  (addr[1]),
        .o_sccb_data  (data[1]),
        .o_sccb_ready (rdy[1]),
        .i_sccb_busy  (sccb_busy[1]),
        .o_busy       (dbusy[1]),
        .o_done       (done[1]),
        .o_error      (err[1]),
        .o_index      (index[1])
    );

    // Writer model: busy rises two cycles after a ready pulse and is held for a fixed time.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rdy_d[i]    <= 1'b0;
                wbusy[i]    <= 1'b0;
                hold_cnt[i] <= 0;
            end else begin
                rdy_d[i] <= rdy[i] & ~never[i];
                if (rdy_d[i]) begin
                    wbusy[i]    <= 1'b1;
                    hold_cnt[i] <= ((i == 0) ? HoldA : HoldB) - 1;
                end else if (wbusy[i]) begin
                    if (hold_cnt[i] == 0) wbusy[i] <= 1'b0;
                    else hold_cnt[i] <= hold_cnt[i] - 1;
                end
            end
        end
    end

    // Advance one cycle and score any ready pulse against the expected-write queue.
    task automatic step();
        logic [15:0] e;
        logic        has;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rdy[i] === 1'b1) begin
                rdy_cnt[i]++;
                e   = 16'h0000;
                has = 1'b0;
                if (i == 0 && exp_a.size() != 0) begin e = exp_a.pop_front(); has = 1'b1; end
                if (i == 1 && exp_b.size() != 0) begin e = exp_b.pop_front(); has = 1'b1; end
                total++;
                if (!has) begin
                    bad++;
                    $display("FAIL unexpected_write dut=%0d got=%h%h required=none", i, addr[i],
                             data[i]);
                end else if ({addr[i], data[i]} !== e) begin
                    bad++;
                    $display("FAIL write_value dut=%0d got=%h%h required=%h", i, addr[i],
                             data[i], e);
                end
                total++;
                if (rdy_prev[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_width dut=%0d got=2+ cycles required=1", i);
                end
            end
            rdy_prev[i] = rdy[i];
        end
    endtask

    function automatic logic cond(input int i, input int sel);
        case (sel)
            CDone:   return done[i] === 1'b1;
            CRdy:    return rdy[i] === 1'b1;
            CErr:    return err[i] === 1'b1;
            CBusyHi: return sccb_busy[i] === 1'b1;
            default: return sccb_busy[i] === 1'b0;
        endcase
    endfunction

    task automatic run_until(input int i, input int sel, input int budget, output int n);
        n = 0;
        while (!cond(i, sel) && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({rdy[i], dbusy[i], done[i], err[i]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_flags dut=%0d got=%b required=0000", i,
                         {rdy[i], dbusy[i], done[i], err[i]});
            end
            total++;
            if ({addr[i], data[i], index[i]} !== 24'h000000) begin
                bad++;
                $display("FAIL reset_regs dut=%0d got=%h required=000000", i,
                         {addr[i], data[i], index[i]});
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (dbusy !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b required=00", dbusy);
        end
    endtask

    task automatic test_three_entry();
        int n;
        rdy_cnt[0] = 0;
        exp_a.push_back(16'h1280);
        pulse_start(0);
        total++;
        if (dbusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got=%b required=1", dbusy[0]);
        end
        run_until(0, CRdy, 20, n);
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL start_latency got=%0d required=3", n);
        end
        run_until(0, CBusyHi, 20, n);
        run_until(0, CBusyLo, 300, n);
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL writer_release timeout got=%0d required<300", n);
        end
        run_until(0, CDone, 3000, n);
        total++;
        if (n !== int'(GapA + DlyCycles + 6)) begin
            bad++;
            $display("FAIL delay_to_done got=%0d required=%0d", n, GapA + DlyCycles + 6);
        end
        total++;
        if ({rdy_cnt[0] == 1, dbusy[0], err[0], index[0]} !== {1'b1, 1'b0, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL three_entry_end got writes=%0d busy=%b err=%b index=%0d required=1 0 0 2",
                     rdy_cnt[0], dbusy[0], err[0], index[0]);
        end
    endtask

    task automatic test_busy_stall();
        int n;
        rdy_cnt[0]    = 0;
        force_busy[0] = 1'b1;
        exp_a.push_back(16'h1280);
        pulse_start(0);
        for (int k = 0; k < 12; k++) step();
        total++;
        if (rdy_cnt[0] !== 0 || {addr[0], data[0]} !== 16'h1280) begin
            bad++;
            $display("FAIL stall got writes=%0d addr_data=%h%h required=0 1280", rdy_cnt[0],
                     addr[0], data[0]);
        end
        force_busy[0] = 1'b0;
        run_until(0, CRdy, 5, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL stall_release_latency got=%0d required=1", n);
        end
        step();
        total++;
        if (rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL stall_pulse got ready=%b required=0", rdy[0]);
        end
        run_until(0, CDone, 3000, n);
        total++;
        if (n >= 3000 || rdy_cnt[0] !== 1) begin
            bad++;
            $display("FAIL stall_done got cycles=%0d writes=%0d required<3000 1", n, rdy_cnt[0]);
        end
    endtask

    task automatic test_accept_timeout();
        int n;
        rdy_cnt[0] = 0;
        never[0]   = 1'b1;
        exp_a.push_back(16'h1280);
        pulse_start(0);
        run_until(0, CRdy, 10, n);
        run_until(0, CErr, AccA + 10, n);
        total++;
        if (n !== int'(AccA)) begin
            bad++;
            $display("FAIL accept_timeout got=%0d required=%0d", n, AccA);
        end
        step();
        total++;
        if ({done[0], dbusy[0]} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_done got done,busy=%b required=10", {done[0], dbusy[0]});
        end
        for (int k = 0; k < 30; k++) step();
        total++;
        if (rdy_cnt[0] !== 1 || err[0] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got writes=%0d err=%b required=1 1", rdy_cnt[0], err[0]);
        end
        never[0] = 1'b0;
    endtask

    task automatic test_start_held();
        int n;
        rdy_cnt[0] = 0;
        exp_a.push_back(16'h1280);
        exp_a.push_back(16'h1280);
        start[0] = 1'b1;
        step();
        total++;
        if ({err[0], dbusy[0]} !== 2'b01) begin
            bad++;
            $display("FAIL restart_clear got err,busy=%b required=01", {err[0], dbusy[0]});
        end
        run_until(0, CDone, 3000, n);
        total++;
        if (n >= 3000 || rdy_cnt[0] !== 1) begin
            bad++;
            $display("FAIL held_first_run got cycles=%0d writes=%0d required<3000 1", n,
                     rdy_cnt[0]);
        end
        step();
        total++;
        if ({done[0], dbusy[0], index[0]} !== {1'b0, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL replay_start got done=%b busy=%b index=%0d required=0 1 0", done[0],
                     dbusy[0], index[0]);
        end
        start[0] = 1'b0;
        run_until(0, CDone, 3000, n);
        total++;
        if (n >= 3000 || rdy_cnt[0] !== 2 || exp_a.size() != 0) begin
            bad++;
            $display("FAIL replay_done got cycles=%0d writes=%0d pending=%0d required<3000 2 0",
                     n, rdy_cnt[0], exp_a.size());
        end
    endtask

    task automatic test_full_table();
        int n;
        rdy_cnt[1] = 0;
        for (int i = 0; i < 256; i++) exp_b.push_back({8'(i), ~8'(i)});
        pulse_start(1);
        run_until(1, CDone, 8000, n);
        total++;
        if (n >= 8000 || rdy_cnt[1] !== 256 || exp_b.size() != 0) begin
            bad++;
            $display("FAIL full_table got cycles=%0d writes=%0d pending=%0d required<8000 256 0",
                     n, rdy_cnt[1], exp_b.size());
        end
        total++;
        if ({index[1], done[1], dbusy[1]} !== {8'd255, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL full_table_end got index=%0d done=%b busy=%b required=255 1 0",
                     index[1], done[1], dbusy[1]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 256; i++) exp_b.push_back({8'(i), ~8'(i)});
        pulse_start(1);
        n = 0;
        while (!(index[1] == 8'd5 && sccb_busy[1] === 1'b1) && n < 300) begin
            step();
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL reach_entry5 timeout got=%0d required<300", n);
        end
        step();
        rst_n = 1'b0;
        step();
        exp_b.delete();
        total++;
        if ({rdy[1], dbusy[1], done[1], err[1], addr[1], data[1], index[1]} !== 28'h0) begin
            bad++;
            $display("FAIL mid_reset got=%h required=0000000",
                     {rdy[1], dbusy[1], done[1], err[1], addr[1], data[1], index[1]});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        total++;
        if ({dbusy[1], rdy[1]} !== 2'b00) begin
            bad++;
            $display("FAIL abandoned got busy,ready=%b required=00", {dbusy[1], rdy[1]});
        end
        rdy_cnt[1] = 0;
        for (int i = 0; i < 256; i++) exp_b.push_back({8'(i), ~8'(i)});
        pulse_start(1);
        run_until(1, CRdy, 10, n);
        total++;
        if (n >= 10 || index[1] !== 8'd0) begin
            bad++;
            $display("FAIL restart_index got cycles=%0d index=%0d required<10 0", n, index[1]);
        end
        run_until(1, CDone, 8000, n);
        total++;
        if (n >= 8000 || rdy_cnt[1] !== 256) begin
            bad++;
            $display("FAIL restart_full got cycles=%0d writes=%0d required<8000 256", n,
                     rdy_cnt[1]);
        end
    endtask

    initial begin
        rdy_cnt[0] = 0;
        rdy_cnt[1] = 0;
        test_reset();
        test_three_entry();
        test_busy_stall();
        test_accept_timeout();
        test_start_held();
        test_full_table();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Sequences the OV7670 power-up register configuration over the SCCB writer. Steps through a register/value table, issues one write per entry through the writer's ready/busy handshake, inserts millisecond delays where the table requests them, and reports completion. Sits between top-level reset/start logic and the SCCB writer; the VGA capture path waits on `o_done`.

## Interface

**Parameters**
- `ClockFrequency`, default 50_000_000 — CLK rate in Hz.
- `DelayMs`, default 10 — wait length in ms for a delay marker entry.
- `GapCycles`, default 64 — idle CLK cycles after each completed write.
- `AcceptTimeout`, default 16 — cycles to wait for the writer's busy to rise after a ready pulse.

**Ports**
- `CLK` — input, 1 — system clock.
- `RST` — input, 1 — synchronous, active-low reset.
- `i_start` — input, 1 — level or pulse; starts the sequence when the block is idle.
- `o_sccb_addr` — output, 8 — register address to the writer.
- `o_sccb_data` — output, 8 — register value to the writer.
- `o_sccb_ready` — output, 1 — single-cycle write request to the writer.
- `i_sccb_busy` — input, 1 — writer busy flag (registered in the writer).
- `o_busy` — output, 1 — sequence in progress.
- `o_done` — output, 1 — table finished; held until the next start or reset.
- `o_error` — output, 1 — writer never accepted a request; sticky until the next start or reset.
- `o_index` — output, 8 — current table index, for debug.

## Operation

- **Table entries** are 16 bits, `{addr[15:8], data[7:0]}`, indexed 0..255.
- **Reserved entries:**
  - 16'hFFFF = end of table.
  - 16'hFFF0 = delay of `DelayMs`; nothing is written.
- **States:**
  - IDLE: on `i_start`=1, set index to 0 and clear `o_done` and `o_error`; go to FETCH.
  - FETCH: present index to the ROM, which has a 1-cycle registered read; go to DECODE.
  - DECODE:
    - End marker → DONE.
    - Delay marker → DELAY.
    - Any other entry: latch `o_sccb_addr` and `o_sccb_data` → ISSUE.
  - ISSUE: requires `i_sccb_busy`=0. Drive `o_sccb_ready`=1 for exactly one cycle, clear the accept counter → WAIT_ACCEPT. If busy=1, stay in ISSUE with ready=0.
  - WAIT_ACCEPT:
    - `i_sccb_busy`=1 → WAIT_DONE.
    - Accept counter reaches `AcceptTimeout` → set `o_error`=1 and go to DONE (abort).
    - The writer's busy rises 2 cycles after ready, so the timeout is never hit in normal operation.
  - WAIT_DONE: on `i_sccb_busy`=0 → GAP.
  - GAP: count `GapCycles`, then increment index → FETCH.
  - DELAY: count `DelayMs`*(`ClockFrequency`/1000) cycles, then increment index → FETCH.
  - DONE: `o_done`=1, `o_busy`=0 → IDLE. `o_done` stays set while idle.
- **Index wrap:** if index 255 is processed without reaching an end marker, the sequence ends as if 256 = end marker. There is no wrap to 0.
- **Start handling:** `i_start` is ignored while `o_busy`=1. A start after DONE replays the whole table.
- **`o_sccb_addr`/`o_sccb_data`** hold their values from DECODE through WAIT_DONE.

## Timing

- **Reset values:**
  - `o_sccb_ready`=0, `o_busy`=0, `o_done`=0, `o_error`=0.
  - `o_sccb_addr`=8'h00, `o_sccb_data`=8'h00, `o_index`=0.
  - State = IDLE, all counters = 0.
- **Start latency:** `i_start` sampled high → `o_busy`=1 next cycle → first `o_sccb_ready` 3 cycles after the start sample (IDLE→FETCH→DECODE→ISSUE).
- **Per-write overhead** beyond the writer's own transfer: 2 (fetch/decode) + 1 (issue) + 2 (accept) + `GapCycles`.
- **Counter widths:** delay counter is $clog2(`DelayMs`*`ClockFrequency`/1000 + 1) bits; gap and accept counters are sized from their parameters.
- **Reset mid-operation:** all outputs return to reset values on the next edge and the sequence is abandoned. The SCCB writer shares RST, so no partial transfer continues.
- **Simultaneous `i_start` and DONE in the same cycle:** DONE has priority; the start is taken in IDLE only.

## Structure

- **Shared package `ov7670_pkg`:**
  - `ENTRY_END`=16'hFFFF, `ENTRY_DELAY`=16'hFFF0.
  - State encoding localparams (4 bits).
  - OV7670 register address constants (COM7=8'h12, CLKRC=8'h11, ...).
- **Sub-module `ov7670_config_rom`:** 8-bit address, 16-bit registered data out. Holds the table (COM7 reset, delay, RGB565/VGA setup, end marker). It is separate so the table can be swapped without touching the sequencer.

## Test plan

1. **Three-entry table** {12 80, FFF0, FFFF}, `DelayMs`=1 at 1 MHz, bus-functional writer model (busy 2 cycles after ready, held 100 cycles):
   - exactly one ready pulse with addr=12, data=80;
   - then 1000 idle cycles;
   - then `o_done`=1, `o_busy`=0.
2. **Writer busy held high at start:** ISSUE stalls with ready=0 until busy falls; ready is then a single 1-cycle pulse.
3. **Writer never raises busy:** `o_error`=1 and `o_done`=1 after `AcceptTimeout` cycles; no second ready pulse.
4. **Full 256 entries with no end marker:** 256 ready pulses, `o_index` stops at 255, `o_done`=1.
5. **RST low during WAIT_DONE at entry 5:** every output reaches its reset value next cycle. Restart after reset begins again at index 0.
6. **`i_start` held high throughout:** no restart while busy. After DONE, the table replays from index 0.
